fab_int_sb_core_uart_apb: RTL and testbench
===========================================

FAB_INT_SB_CORE_UART_APB -- requirements
Module: fab_int_sb_core_uart_apb

Interface
REQ-001 SHALL have parameter FAMILY, default 19: target family; no functional effect.
REQ-002 SHALL have parameters TX_FIFO and RX_FIFO, default 0: accepted; data path is always single-entry holding registers.
REQ-003 SHALL have parameter FIXEDMODE, default 0: 1 = use BAUD_VALUE, PRG_BIT8 and PRG_PARITY; 0 = use the control registers.
REQ-004 SHALL have parameter BAUD_VALUE, default 1: 13-bit fixed baud divisor.
REQ-005 SHALL have parameter PRG_BIT8, default 1: fixed mode data width; 1 = 8 bits, 0 = 7 bits.
REQ-006 SHALL have parameter PRG_PARITY, default 0: fixed mode parity; 0 = none, 1 = even, 2 = odd.
REQ-007 SHALL have parameter RX_LEGACY_MODE, default 0: 1 = RXRDY set at mid-stop-bit; 0 = set one bit-time later.
REQ-008 SHALL have parameters BAUD_VAL_FRCTN (0..7, default 0) and BAUD_VAL_FRCTN_EN (default 0): fractional baud extension.
REQ-009 SHALL have ports PCLK in 1 (sole clock, rising edge) and PRESETN in 1; PRESETN is asynchronous and active-high (asserted when 1), port name kept as the codebase names it.
REQ-010 SHALL have APB ports PSEL in 1, PENABLE in 1, PWRITE in 1, PADDR in 5, PWDATA in 8, PRDATA out 8, PREADY out 1 (constant 1), PSLVERR out 1 (constant 0).
REQ-011 SHALL have serial ports RX in 1 and TX out 1.
REQ-012 SHALL have status outputs TXRDY, RXRDY, PARITY_ERR, FRAMING_ERR, OVERFLOW, each 1 bit.

Function
REQ-013 SHALL decode PADDR[4:2]: 0 TXDATA (W), 1 RXDATA (R), 2 CTRL1 (baud[7:0]), 3 CTRL2, 4 STATUS (R), 5 CTRL3 (frac[2:0]); other offsets read 0x00, writes ignored.
REQ-014 SHALL define CTRL2 as: [0] bit8, [1] parity enable, [2] odd (1) / even (0), [7:3] baud[12:8].
REQ-015 SHALL define STATUS as: [0] TXRDY, [1] RXRDY, [2] PARITY_ERR, [3] OVERFLOW, [4] FRAMING_ERR.
REQ-016 SHALL take writes on PSEL&PENABLE&PWRITE at the PCLK edge; PRDATA is combinational from PADDR whenever PSEL=1 and PWRITE=0; zero wait states.
REQ-017 SHALL generate a 16x tick: a down-counter reloads the divisor and pulses when it reaches 0, giving baud = PCLK/(16*(divisor+1)).
REQ-018 SHALL, when BAUD_VAL_FRCTN_EN=1, add one PCLK to the tick period in frac of every 8 tick periods.
REQ-019 SHALL clear TXRDY on a TXDATA write; data transfers to the shifter when idle, and TXRDY re-asserts the cycle after the transfer.
REQ-020 SHALL ignore a TXDATA write while TXRDY=0.
REQ-021 SHALL serialize each frame LSB first, 16 ticks per bit: start bit 0, 7 or 8 data bits, optional parity bit, one stop bit 1; TX idles at 1.
REQ-022 SHALL double-flop RX and detect a start on a falling edge; it requalifies the start at tick 8 (returns to idle if RX=1), then samples each bit 16 ticks later.
REQ-023 SHALL, on frame completion, load RXDATA, set RXRDY, set PARITY_ERR on parity mismatch, and set FRAMING_ERR if the stop sample is 0.
REQ-024 SHALL, if a frame completes while RXRDY=1, set OVERFLOW and discard the new byte, keeping the old one.
REQ-025 SHALL, on an APB read of RXDATA, clear RXRDY, PARITY_ERR, OVERFLOW and FRAMING_ERR on the next edge.
REQ-026 SHALL read bit 7 of RXDATA as 0 in 7-bit mode.

Reset
REQ-027 SHALL, with PRESETN=1, asynchronously set: TX=1, TXRDY=1, RXRDY=0, all error flags 0, control registers 0, both FSMs idle, baud counter 0.

Structure
REQ-028 SHALL place register offsets, STATUS bit indices and the FSM state encodings (IDLE, START, DATA, PARITY, STOP) in a shared package.
REQ-029 SHALL implement the baud/tick generator as one sub-module, uart_baud_gen; TX and RX FSMs stay in the top module.

Verification
REQ-030 SHALL cover loopback: two instances, BAUD_VALUE=1, 8N1, TX1->RX2; write 0x55 to DUT1 TXDATA -> RXRDY2=1 after about 320 PCLKs; RXDATA2 reads 0x55; RXRDY2 then 0.
REQ-031 SHALL cover parity error: DUT1 odd, DUT2 even, send 0xA3 -> PARITY_ERR2=1; read of RXDATA2 clears it.
REQ-032 SHALL cover framing error: RX2 forced to 0 -> FRAMING_ERR2=1 and RXDATA2 reads 0x00.
REQ-033 SHALL cover overflow: send 0x11 then 0x22 with no read -> OVERFLOW2=1; RXDATA2 reads 0x11.
REQ-034 SHALL cover reset mid-frame: assert PRESETN during a data bit -> TX=1 and TXRDY=1 immediately, STATUS reads 0x01.
REQ-035 SHALL cover 7-bit mode: CTRL2=0x00, send 0xFF -> RXDATA2 reads 0x7F.

Source files
------------

// File: rtl/fab_int_sb_core_uart_apb_pkg.sv
// Shared definitions for the APB UART core: register map, status bit positions,
// serial FSM states and the parity helper used by both TX and RX.
package fab_int_sb_core_uart_apb_pkg;

  localparam logic [2:0] OFF_TXDATA = 3'd0;
  localparam logic [2:0] OFF_RXDATA = 3'd1;
  localparam logic [2:0] OFF_CTRL1  = 3'd2;
  localparam logic [2:0] OFF_CTRL2  = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;
  localparam logic [2:0] OFF_CTRL3  = 3'd5;

  localparam int ST_TXRDY       = 0;
  localparam int ST_RXRDY       = 1;
  localparam int ST_PARITY_ERR  = 2;
  localparam int ST_OVERFLOW    = 3;
  localparam int ST_FRAMING_ERR = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } uart_state_e;

  // Parity bit to transmit (or expect): even parity unless odd is set; bit 7 ignored in 7-bit mode.
  function automatic logic calc_parity(input logic [7:0] data, input logic bit8, input logic odd);
    return (^{data[7] & bit8, data[6:0]}) ^ odd;
  endfunction

endpackage

// File: rtl/fab_int_sb_core_uart_apb_baud.sv
// 16x oversampling tick generator: down-counter reloaded with the divisor,
// optionally stretched by one clock in `frac` out of every 8 tick periods.
module uart_baud_gen (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [12:0] baud_val_i,
  input  logic        frac_en_i,
  input  logic [2:0]  frac_i,
  output logic        tick_o
);

  logic [13:0] cnt_q, cnt_d;
  logic [2:0]  phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q - 14'd1;
    phase_d = phase_q;
    tick_o  = 1'b0;
    if (cnt_q == 14'd0) begin
      tick_o  = 1'b1;
      phase_d = phase_q + 3'd1;
      cnt_d   = {1'b0, baud_val_i} + ((frac_en_i && (phase_q < frac_i)) ? 14'd1 : 14'd0);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      phase_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/fab_int_sb_core_uart_apb.sv
// APB-attached UART with single-entry TX/RX holding registers; TX and RX
// serial FSMs live here, the baud tick comes from uart_baud_gen.
module fab_int_sb_core_uart_apb
  import fab_int_sb_core_uart_apb_pkg::*;
#(
  parameter int FAMILY            = 19,
  parameter int TX_FIFO           = 0,
  parameter int RX_FIFO           = 0,
  parameter int FIXEDMODE         = 0,
  parameter int BAUD_VALUE        = 1,
  parameter int PRG_BIT8          = 1,
  parameter int PRG_PARITY        = 0,
  parameter int RX_LEGACY_MODE    = 0,
  parameter int BAUD_VAL_FRCTN    = 0,
  parameter int BAUD_VAL_FRCTN_EN = 0
) (
  input  logic       PCLK,
  input  logic       PRESETN,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [4:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR,
  input  logic       RX,
  output logic       TX,
  output logic       TXRDY,
  output logic       RXRDY,
  output logic       PARITY_ERR,
  output logic       FRAMING_ERR,
  output logic       OVERFLOW
);

  logic [7:0]  ctrl1_q, ctrl2_q;
  logic [2:0]  ctrl3_q;
  logic [12:0] baud_val;
  logic [2:0]  frac, last_bit;
  logic        bit8, par_en, par_odd, frac_en, tick;
  logic [2:0]  addr;
  logic        wr_en, rd_clr;
  logic [7:0]  status;
  logic        unused_ok;

  assign addr      = PADDR[4:2];
  assign wr_en     = PSEL & PENABLE & PWRITE;
  assign rd_clr    = PSEL & PENABLE & ~PWRITE & (addr == OFF_RXDATA);
  assign PREADY    = 1'b1;
  assign PSLVERR   = 1'b0;
  assign unused_ok = ^{PADDR[1:0], ((FAMILY + TX_FIFO + RX_FIFO) != 0)};

  always_comb begin
    baud_val = (FIXEDMODE != 0) ? 13'(BAUD_VALUE) : {ctrl2_q[7:3], ctrl1_q};
    bit8     = (FIXEDMODE != 0) ? (PRG_BIT8 != 0) : ctrl2_q[0];
    par_en   = (FIXEDMODE != 0) ? (PRG_PARITY != 0) : ctrl2_q[1];
    par_odd  = (FIXEDMODE != 0) ? (PRG_PARITY == 2) : ctrl2_q[2];
    frac     = (FIXEDMODE != 0) ? 3'(BAUD_VAL_FRCTN) : ctrl3_q;
    frac_en  = (BAUD_VAL_FRCTN_EN != 0);
    last_bit = bit8 ? 3'd7 : 3'd6;
  end

  always_ff @(posedge PCLK or posedge PRESETN) begin
    if (PRESETN) begin
      ctrl1_q <= '0;
      ctrl2_q <= '0;
      ctrl3_q <= '0;
    end else if (wr_en) begin
      if (addr == OFF_CTRL1) ctrl1_q <= PWDATA;
      if (addr == OFF_CTRL2) ctrl2_q <= PWDATA;
      if (addr == OFF_CTRL3) ctrl3_q <= PWDATA[2:0];
    end
  end

  uart_baud_gen u_baud (
    .clk_i      (PCLK),
    .rst_i      (PRESETN),
    .baud_val_i (baud_val),
    .frac_en_i  (frac_en),
    .frac_i     (frac),
    .tick_o     (tick)
  );

  // ---------------- transmitter ----------------
  uart_state_e tx_state_q, tx_state_d;
  logic [3:0]  tx_tcnt_q, tx_tcnt_d;
  logic [2:0]  tx_bcnt_q, tx_bcnt_d;
  logic [7:0]  tx_shift_q, tx_shift_d, tx_buf_q, tx_buf_d;
  logic        tx_par_q, tx_par_d, txrdy_q, txrdy_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bcnt_d  = tx_bcnt_q;
    tx_shift_d = tx_shift_q;
    tx_buf_d   = tx_buf_q;
    tx_par_d   = tx_par_q;
    txrdy_d    = txrdy_q;
    if (wr_en && (addr == OFF_TXDATA) && txrdy_q) begin
      tx_buf_d = PWDATA;
      txrdy_d  = 1'b0;
    end
    case (tx_state_q)
      S_IDLE: begin
        if (!txrdy_q) begin
          tx_shift_d = tx_buf_q;
          tx_par_d   = calc_parity(tx_buf_q, bit8, par_odd);
          tx_tcnt_d  = '0;
          tx_bcnt_d  = '0;
          txrdy_d    = 1'b1;
          tx_state_d = S_START;
        end
      end
      default: begin
        if (tick) begin
          tx_tcnt_d = tx_tcnt_q + 4'd1;
          if (tx_tcnt_q == 4'd15) begin
            case (tx_state_q)
              S_START:  tx_state_d = S_DATA;
              S_DATA: begin
                tx_shift_d = {1'b0, tx_shift_q[7:1]};
                tx_bcnt_d  = tx_bcnt_q + 3'd1;
                if (tx_bcnt_q == last_bit) tx_state_d = par_en ? S_PARITY : S_STOP;
              end
              S_PARITY: tx_state_d = S_STOP;
              default:  tx_state_d = S_IDLE;
            endcase
          end
        end
      end
    endcase
  end

  always_comb begin
    case (tx_state_q)
      S_START:  TX = 1'b0;
      S_DATA:   TX = tx_shift_q[0];
      S_PARITY: TX = tx_par_q;
      default:  TX = 1'b1;
    endcase
  end

  // ---------------- receiver ----------------
  uart_state_e rx_state_q, rx_state_d;
  logic [3:0]  rx_tcnt_q, rx_tcnt_d;
  logic [2:0]  rx_bcnt_q, rx_bcnt_d;
  logic [7:0]  rx_shift_q, rx_shift_d, rxdata_q, rxdata_d, rx_byte;
  logic        rx_meta_q, rx_sync_q, rx_prev_q, rx_fall;
  logic        rx_par_q, rx_par_d, rx_stop_q, rx_stop_d, rx_wait_q, rx_wait_d;
  logic        rx_done, rx_stop_bit;
  logic        rxrdy_q, rxrdy_d, perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;

  assign rx_fall     = rx_prev_q & ~rx_sync_q;
  assign rx_byte     = bit8 ? rx_shift_q : {1'b0, rx_shift_q[7:1]};
  assign rx_stop_bit = rx_wait_q ? rx_stop_q : rx_sync_q;

  // Outside legacy mode the frame completes one bit-time after mid-stop, or
  // early if the next start edge shows up during that wait.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tcnt_d  = rx_tcnt_q;
    rx_bcnt_d  = rx_bcnt_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_stop_d  = rx_stop_q;
    rx_wait_d  = rx_wait_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (rx_fall) begin
          rx_tcnt_d  = '0;
          rx_state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          rx_tcnt_d = rx_tcnt_q + 4'd1;
          if (rx_tcnt_q == 4'd7) begin
            rx_tcnt_d  = '0;
            rx_bcnt_d  = '0;
            rx_wait_d  = 1'b0;
            rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          rx_tcnt_d = rx_tcnt_q + 4'd1;
          if (rx_tcnt_q == 4'd15) begin
            rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
            rx_bcnt_d  = rx_bcnt_q + 3'd1;
            if (rx_bcnt_q == last_bit) rx_state_d = par_en ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          rx_tcnt_d = rx_tcnt_q + 4'd1;
          if (rx_tcnt_q == 4'd15) begin
            rx_par_d   = rx_sync_q;
            rx_state_d = S_STOP;
          end
        end
      end
      default: begin
        if (rx_wait_q && rx_fall) begin
          rx_done    = 1'b1;
          rx_wait_d  = 1'b0;
          rx_tcnt_d  = '0;
          rx_state_d = S_START;
        end else if (tick) begin
          rx_tcnt_d = rx_tcnt_q + 4'd1;
          if (rx_tcnt_q == 4'd15) begin
            if (!rx_wait_q) rx_stop_d = rx_sync_q;
            if (rx_wait_q || (RX_LEGACY_MODE != 0)) begin
              rx_done    = 1'b1;
              rx_wait_d  = 1'b0;
              rx_state_d = S_IDLE;
            end else begin
              rx_wait_d = 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_comb begin
    rxdata_d = rxdata_q;
    rxrdy_d  = rxrdy_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    ovf_d    = ovf_q;
    if (rd_clr) begin
      rxrdy_d = 1'b0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      ovf_d   = 1'b0;
    end
    if (rx_done) begin
      if (rxrdy_q && !rd_clr) begin
        ovf_d = 1'b1;
      end else begin
        rxdata_d = rx_byte;
        rxrdy_d  = 1'b1;
        perr_d   = par_en && (rx_par_q != calc_parity(rx_byte, bit8, par_odd));
        ferr_d   = ~rx_stop_bit;
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESETN) begin
    if (PRESETN) begin
      tx_state_q <= S_IDLE;
      tx_tcnt_q  <= '0;
      tx_bcnt_q  <= '0;
      tx_shift_q <= '0;
      tx_buf_q   <= '0;
      tx_par_q   <= 1'b0;
      txrdy_q    <= 1'b1;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_tcnt_q  <= '0;
      rx_bcnt_q  <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      rx_stop_q  <= 1'b1;
      rx_wait_q  <= 1'b0;
      rxdata_q   <= '0;
      rxrdy_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bcnt_q  <= tx_bcnt_d;
      tx_shift_q <= tx_shift_d;
      tx_buf_q   <= tx_buf_d;
      tx_par_q   <= tx_par_d;
      txrdy_q    <= txrdy_d;
      rx_meta_q  <= RX;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_tcnt_q  <= rx_tcnt_d;
      rx_bcnt_q  <= rx_bcnt_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      rx_stop_q  <= rx_stop_d;
      rx_wait_q  <= rx_wait_d;
      rxdata_q   <= rxdata_d;
      rxrdy_q    <= rxrdy_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    status                 = '0;
    status[ST_TXRDY]       = txrdy_q;
    status[ST_RXRDY]       = rxrdy_q;
    status[ST_PARITY_ERR]  = perr_q;
    status[ST_OVERFLOW]    = ovf_q;
    status[ST_FRAMING_ERR] = ferr_q;
  end

  always_comb begin
    PRDATA = 8'h00;
    if (PSEL && !PWRITE) begin
      case (addr)
        OFF_RXDATA: PRDATA = {rxdata_q[7] & bit8, rxdata_q[6:0]};
        OFF_CTRL1:  PRDATA = ctrl1_q;
        OFF_CTRL2:  PRDATA = ctrl2_q;
        OFF_STATUS: PRDATA = status;
        OFF_CTRL3:  PRDATA = {5'b0, ctrl3_q};
        default:    PRDATA = 8'h00;
      endcase
    end
  end

  assign TXRDY       = txrdy_q;
  assign RXRDY       = rxrdy_q;
  assign PARITY_ERR  = perr_q;
  assign FRAMING_ERR = ferr_q;
  assign OVERFLOW    = ovf_q;

endmodule

// File: tb/tb_fab_int_sb_core_uart_apb.sv
// Two UART instances in loopback (DUT1 TX -> DUT2 RX); frames and received
// bytes are predicted from the serial frame format and checked with assertions.
module tb_fab_int_sb_core_uart_apb;
  import fab_int_sb_core_uart_apb_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       psel[2], penable[2], pwrite[2];
  logic [4:0] paddr[2];
  logic [7:0] pwdata[2];
  logic [7:0] prdata[2];
  logic       pready[2], pslverr[2], txrdy[2], rxrdy[2], perr[2], ferr[2], ovf[2];
  logic       tx1, tx2, rx2, rx_force;
  int         n_checks = 0;
  int         n_pass = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;
  assign rx2 = rx_force ? 1'b0 : tx1;

  fab_int_sb_core_uart_apb dut1 (
    .PCLK(clk), .PRESETN(rst), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0]), .RX(tx2), .TX(tx1), .TXRDY(txrdy[0]), .RXRDY(rxrdy[0]),
    .PARITY_ERR(perr[0]), .FRAMING_ERR(ferr[0]), .OVERFLOW(ovf[0])
  );

  fab_int_sb_core_uart_apb dut2 (
    .PCLK(clk), .PRESETN(rst), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1]), .RX(rx2), .TX(tx2), .TXRDY(txrdy[1]), .RXRDY(rxrdy[1]),
    .PARITY_ERR(perr[1]), .FRAMING_ERR(ferr[1]), .OVERFLOW(ovf[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apb_wr(input int w, input logic [2:0] off, input logic [7:0] d);
    @(negedge clk);
    psel[w] = 1'b1; pwrite[w] = 1'b1; penable[w] = 1'b0; paddr[w] = {off, 2'b00}; pwdata[w] = d;
    @(negedge clk);
    penable[w] = 1'b1;
    @(negedge clk);
    psel[w] = 1'b0; penable[w] = 1'b0; pwrite[w] = 1'b0;
  endtask

  task automatic apb_rd(input int w, input logic [2:0] off, output logic [7:0] d);
    @(negedge clk);
    psel[w] = 1'b1; pwrite[w] = 1'b0; penable[w] = 1'b0; paddr[w] = {off, 2'b00};
    @(negedge clk);
    penable[w] = 1'b1;
    #1 d = prdata[w];
    @(negedge clk);
    psel[w] = 1'b0; penable[w] = 1'b0;
  endtask

  task automatic cfg_both(input logic [7:0] c1, input logic [7:0] c2_1, input logic [7:0] c2_2);
    apb_wr(0, OFF_CTRL1, c1);
    apb_wr(1, OFF_CTRL1, c1);
    apb_wr(0, OFF_CTRL2, c2_1);
    apb_wr(1, OFF_CTRL2, c2_2);
  endtask

  // Reference frame: start 0, data LSB first (7 or 8 bits), optional parity, stop 1.
  function automatic int build_frame(input logic [7:0] d, input bit b8, input bit pen,
                                     input bit odd, output logic [10:0] f);
    int nd;
    int n;
    logic [7:0] m;
    nd = b8 ? 8 : 7;
    m = b8 ? d : (d & 8'h7F);
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < nd; i++) f[1 + i] = m[i];
    n = 1 + nd;
    if (pen) begin
      f[n] = (($countones(m) % 2) == 1) ^ odd;
      n++;
    end
    f[n] = 1'b1;
    return n + 1;
  endfunction

  // Writes d to DUT1, samples TX1 at each bit centre (32 PCLKs per bit) and waits for RXRDY2.
  task automatic send_cap(input logic [7:0] d, input int n, output logic [10:0] obs,
                          output int lat, output bit got);
    int fall_c;
    int rel;
    fall_c = -1;
    obs = '1;
    got = 1'b0;
    lat = 0;
    apb_wr(0, OFF_TXDATA, d);
    chk("txrdy_cleared_on_write", txrdy[0], 1'b0);
    for (int c = 1; c < 700 && !got; c++) begin
      @(negedge clk);
      if (fall_c < 0 && tx1 == 1'b0) fall_c = c;
      if (fall_c >= 0) begin
        rel = c - fall_c;
        if (rel >= 16 && ((rel - 16) % 32) == 0 && ((rel - 16) / 32) < n)
          obs[(rel - 16) / 32] = tx1;
      end
      if (rxrdy[1]) begin
        got = 1'b1;
        lat = c;
      end
    end
  endtask

  task automatic wait_flag(input int which, output bit got);
    got = 1'b0;
    for (int c = 0; c < 800 && !got; c++) begin
      @(negedge clk);
      case (which)
        0: got = rxrdy[1];
        1: got = ovf[1];
        default: got = ferr[1];
      endcase
    end
  endtask

  initial begin
    logic [10:0] ef, obs;
    logic [7:0]  d, rd;
    logic [7:0]  c2;
    int          n, lat;
    bit          got, b8, pen, odd;

    rst = 1'b1;
    rx_force = 1'b0;
    for (int w = 0; w < 2; w++) begin
      psel[w] = 1'b0; penable[w] = 1'b0; pwrite[w] = 1'b0; paddr[w] = '0; pwdata[w] = '0;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("reset_tx_idle", tx1, 1'b1);
    chk("reset_txrdy", txrdy[0], 1'b1);
    chk("reset_rxrdy", rxrdy[1], 1'b0);
    chk("pready_pslverr", {pready[0], pslverr[0]}, 2'b10);
    @(negedge clk);
    rst = 1'b0;
    apb_rd(1, OFF_STATUS, rd);
    chk("reset_status", rd, 8'h01);
    apb_rd(0, OFF_CTRL1, rd);
    chk("reset_ctrl1", rd, 8'h00);

    cfg_both(8'h01, 8'h01, 8'h01);
    apb_rd(1, OFF_CTRL2, rd);
    chk("ctrl2_readback", rd, 8'h01);
    apb_wr(1, 3'd7, 8'hAA);
    apb_rd(1, 3'd7, rd);
    chk("unmapped_reads_zero", rd, 8'h00);

    // 8N1 loopback of 0x55
    n = build_frame(8'h55, 1, 0, 0, ef);
    send_cap(8'h55, n, obs, lat, got);
    chk("frame_55", obs, ef);
    chk("rxrdy_55", got, 1'b1);
    chk("latency_55_in_range", (lat >= 300 && lat <= 380), 1'b1);
    apb_rd(1, OFF_RXDATA, rd);
    chk("rxdata_55", rd, 8'h55);
    chk("rxrdy_cleared", rxrdy[1], 1'b0);

    // random bytes under random formats, identical on both ends
    for (int r = 0; r < 6; r++) begin
      b8 = 1'($urandom_range(0, 1));
      pen = 1'($urandom_range(0, 1));
      odd = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      c2 = {5'b0, odd, pen, b8};
      cfg_both(8'h01, c2, c2);
      n = build_frame(d, b8, pen, odd, ef);
      send_cap(d, n, obs, lat, got);
      chk("rand_frame", obs, ef);
      chk("rand_rxrdy", got, 1'b1);
      apb_rd(1, OFF_STATUS, rd);
      chk("rand_status", rd, 8'h03);
      apb_rd(1, OFF_RXDATA, rd);
      chk("rand_rxdata", rd, b8 ? d : (d & 8'h7F));
    end

    // back-to-back writes: second is buffered, third (while TXRDY=0) is dropped
    cfg_both(8'h01, 8'h01, 8'h01);
    apb_wr(0, OFF_TXDATA, 8'h3C);
    apb_wr(0, OFF_TXDATA, 8'hC3);
    repeat (5) @(negedge clk);
    chk("txrdy_low_buffer_full", txrdy[0], 1'b0);
    apb_wr(0, OFF_TXDATA, 8'hFF);
    wait_flag(0, got);
    chk("b2b_first_rx", got, 1'b1);
    apb_rd(1, OFF_RXDATA, rd);
    chk("b2b_first_data", rd, 8'h3C);
    wait_flag(0, got);
    chk("b2b_second_rx", got, 1'b1);
    apb_rd(1, OFF_RXDATA, rd);
    chk("b2b_second_data", rd, 8'hC3);
    repeat (400) @(negedge clk);
    chk("third_write_ignored", rxrdy[1], 1'b0);

    // parity mismatch: DUT1 odd, DUT2 even
    cfg_both(8'h01, 8'h07, 8'h03);
    n = build_frame(8'hA3, 1, 1, 1, ef);
    send_cap(8'hA3, n, obs, lat, got);
    chk("frame_odd_a3", obs, ef);
    chk("parity_err_set", perr[1], 1'b1);
    apb_rd(1, OFF_STATUS, rd);
    chk("parity_status", rd, 8'h07);
    apb_rd(1, OFF_RXDATA, rd);
    chk("parity_rxdata", rd, 8'hA3);
    chk("parity_err_cleared", perr[1], 1'b0);

    // framing: RX2 held low
    cfg_both(8'h01, 8'h01, 8'h01);
    rx_force = 1'b1;
    wait_flag(2, got);
    chk("framing_err_set", got, 1'b1);
    apb_rd(1, OFF_RXDATA, rd);
    chk("framing_rxdata", rd, 8'h00);
    chk("framing_err_cleared", ferr[1], 1'b0);
    rx_force = 1'b0;
    repeat (50) @(negedge clk);

    // overflow: second byte arrives before the first is read
    n = build_frame(8'h11, 1, 0, 0, ef);
    send_cap(8'h11, n, obs, lat, got);
    chk("ovf_first_rx", got, 1'b1);
    apb_wr(0, OFF_TXDATA, 8'h22);
    wait_flag(1, got);
    chk("overflow_set", got, 1'b1);
    apb_rd(1, OFF_STATUS, rd);
    chk("overflow_status", rd, 8'h0B);
    apb_rd(1, OFF_RXDATA, rd);
    chk("overflow_keeps_old", rd, 8'h11);
    apb_rd(1, OFF_STATUS, rd);
    chk("overflow_cleared", rd, 8'h01);

    // 7-bit mode
    cfg_both(8'h01, 8'h00, 8'h00);
    n = build_frame(8'hFF, 0, 0, 0, ef);
    send_cap(8'hFF, n, obs, lat, got);
    chk("frame_7bit", obs, ef);
    apb_rd(1, OFF_RXDATA, rd);
    chk("rxdata_7bit", rd, 8'h7F);

    // reset during data bit 2 of 0x5A (a 0 bit)
    apb_wr(0, OFF_TXDATA, 8'h5A);
    repeat (100) @(negedge clk);
    chk("mid_frame_tx_low", tx1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_tx", tx1, 1'b1);
    chk("async_reset_txrdy", txrdy[0], 1'b1);
    @(negedge clk);
    rst = 1'b0;
    apb_rd(0, OFF_STATUS, rd);
    chk("post_reset_status", rd, 8'h01);
    apb_rd(0, OFF_CTRL1, rd);
    chk("post_reset_ctrl1", rd, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
